shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the multi-cycle CPU datapath.
- Drives the single-step shift operation repeatedly, one bit per clock, to perform an N-bit shift, rotate or arithmetic shift.
- Uses a start/busy/done handshake with the control FSM.
- Returns the final value and the last bit shifted out (carry) to the ALU/flag logic.

Parameters:
- WIDTH, 8, data width in bits.
- AMT_W, 3, width of the shift amount; amounts range 0..2^AMT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- data_in  input  WIDTH  operand, captured on an accepted start.
- sh_type  input  3  operation, captured on an accepted start: 0 ROL, 1 ROR, 2 SHL, 3 ASR, 4 LSR, 5..7 no-op.
- amount  input  AMT_W  number of single-bit steps, captured on an accepted start.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; result and carry are valid.
- result  output  WIDTH  shifted value; held until the next accepted start.
- carry  output  1  bit shifted out by the final step; held with result.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state IDLE, result=0, carry=0, busy=0, done=0, counter=0.
- rst wins over every other input in any state, including mid-operation. The operation in flight is discarded and no done is issued.
- State IDLE:
  - start=1 captures data_in into the work register, clears carry and latches sh_type and amount.
  - Goes to SHIFT if amount!=0, else to DONE.
  - start=0 holds all registers.
- State SHIFT, on each edge:
  - work = step(work); carry = bit leaving the register; count decrements.
  - When count reaches 0, go to DONE.
- State DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Step definitions and carry source:
  - ROL: {w[6:0],w[7]}, carry=w[7].
  - ROR: {w[0],w[7:1]}, carry=w[0].
  - SHL: {w[6:0],0}, carry=w[7].
  - ASR: {w[7],w[7:1]}, carry=w[0].
  - LSR: {0,w[7:1]}, carry=w[0].
  - Types 5..7: w unchanged, carry=0. Steps still consume cycles; latency is unchanged.
- Latency: start high in cycle 0 gives done high in cycle amount+1. amount=0 gives done in cycle 1 with result=data_in and carry=0.
- result always reflects the work register. It updates during SHIFT and is only guaranteed valid when done=1 and afterwards.
- start while busy (SHIFT or DONE) is ignored with no queueing. Minimum spacing between accepted starts is amount+2 cycles.
- amount at its maximum (7) runs exactly 7 steps. There is no wrap or modulo behaviour.

Optional Feature:
- Macro: SHIFT_SEQ_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit), registered alongside result.
  - zero = (result==WIDTH'b0), updated on every work-register write. Reset value 1.
- Undefined: port absent; no other behaviour changes.

Decomposition:
- Shared package:
  - sh_type encodings SH_ROL=3'd0, SH_ROR=3'd1, SH_SHL=3'd2, SH_ASR=3'd3, SH_LSR=3'd4.
  - State encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step, a combinational single-bit step.
  - Inputs: w, sh_type. Outputs: next w and the carry bit.
  - Instantiated once, in the SHIFT datapath.

Test Plan:
- Reset, then data_in=0x96, ROL, amount=3 -> done in cycle 4, result=0xB4, carry=0, busy high cycles 1..4.
- data_in=0x96, ASR, amount=2 -> result=0xE5, carry=1, done in cycle 3.
- data_in=0x81, SHL, amount=1 -> result=0x02, carry=1. Then data_in=0x81, LSR, amount=7 -> result=0x01, carry=0, done in cycle 8.
- data_in=0x5A, ROR, amount=0 -> done in cycle 1, result=0x5A, carry=0. Then sh_type=6, data_in=0x3C, amount=4 -> result=0x3C, carry=0, done in cycle 5.
- Start 0x0F ROL amount=5; pulse start with data_in=0xFF in cycles 2 and 6 -> both ignored, result=0xE1, carry=1. The first start after the return to IDLE is accepted.
- Start 0x96 LSR amount=6; assert rst in cycle 3 -> next cycle result=0, carry=0, busy=0, no done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: operation codes
// and controller state names used by the top and the single-step datapath.
package shift_sequencer_pkg;

  // Operation codes carried on sh_type; 5..7 are no-ops.
  localparam logic [2:0] SH_ROL = 3'd0;
  localparam logic [2:0] SH_ROR = 3'd1;
  localparam logic [2:0] SH_SHL = 3'd2;
  localparam logic [2:0] SH_ASR = 3'd3;
  localparam logic [2:0] SH_LSR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_step.sv
// shift_step: combinational single-bit shift/rotate step. Produces the next
// work-register value and the bit that leaves the register on this step.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic [2:0]       sh_type,
  output logic [WIDTH-1:0] w_next,
  output logic             carry
);

  // One step of the selected operation; unknown codes pass w through.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_next = w;
    carry  = 1'b0;
    case (sh_type)
      SH_ROL: begin
        w_next = {w[WIDTH-2:0], w[WIDTH-1]};
        carry  = w[WIDTH-1];
      end
      SH_ROR: begin
        w_next = {w[0], w[WIDTH-1:1]};
        carry  = w[0];
      end
      SH_SHL: begin
        w_next = {w[WIDTH-2:0], 1'b0};
        carry  = w[WIDTH-1];
      end
      SH_ASR: begin
        w_next = {w[WIDTH-1], w[WIDTH-1:1]};
        carry  = w[0];
      end
      SH_LSR: begin
        w_next = {1'b0, w[WIDTH-1:1]};
        carry  = w[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift unit. Accepts a start in IDLE, then
// applies one single-bit step per clock for 'amount' cycles and pulses done
// with the final value and the last bit shifted out.
// Optional: define SHIFT_SEQ_ZERO_FLAG_EN to add a registered 'zero' output
// that tracks (result == 0).
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       sh_type,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             carry_q;
  logic [AMT_W-1:0] count;
  logic [2:0]       type_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] step_w;
  logic             step_c;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w       (work),
    .sh_type (type_q),
    .w_next  (step_w),
    .carry   (step_c)
  );

  // Controller and datapath: capture on start, step until count hits zero,
  // then a single DONE cycle before returning to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state   <= ST_IDLE;
      work    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      type_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work    <= data_in;
            carry_q <= 1'b0;
            type_q  <= sh_type;
            count   <= amount;
            busy_q  <= 1'b1;
            if (amount != '0) begin
              state <= ST_SHIFT;
            end else begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          work    <= step_w;
          carry_q <= step_c;
          count   <= count - 1'b1;
          if (count == AMT_W'(1)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic zero_q;

  // Zero flag follows every write of the work register.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else if (state == ST_IDLE && start) begin
      zero_q <= (data_in == '0);
    end else if (state == ST_SHIFT) begin
      zero_q <= (step_w == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = work;
  assign carry  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed operations push their
// hand-computed result, carry and done cycle into a scoreboard; a monitor
// pops and compares whenever done is seen.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [2:0] sh_type;
  logic [2:0] amount;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic       zero;
`endif

  typedef struct {
    logic [7:0] res;
    logic       c;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .sh_type (sh_type),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry)
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    ,
    .zero    (zero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("carry", carry, e.c);
        check("done_cycle", cyc, e.cyc);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        check("zero", zero, e.res == 8'h00);
`endif
      end
    end
  end

  // Drive one start cycle; returns one cycle later with start low.
  task automatic issue(input logic [7:0] d, input logic [2:0] t, input logic [2:0] a,
                       input bit expect_done, input logic [7:0] er, input logic ec);
    data_in = d;
    sh_type = t;
    amount  = a;
    start   = 1'b1;
    if (expect_done) sb.push_back('{res: er, c: ec, cyc: cyc + int'(a) + 1});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    sh_type = 3'd0;
    amount  = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 8'h00);
    check("reset_carry", carry, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    check("reset_zero", zero, 1);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // ROL 0x96 by 3 -> 0xB4, carry 0; busy in cycles 1..4 only.
    issue(8'h96, 3'd0, 3'd3, 1'b1, 8'hB4, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("busy_c%0d", i), busy, 1);
      @(posedge clk); #1;
    end
    check("busy_c5", busy, 0);
    wait_drain(20);

    // ASR 0x96 by 2 -> 0xE5, carry 1.
    issue(8'h96, 3'd3, 3'd2, 1'b1, 8'hE5, 1'b1);
    wait_drain(20);

    // SHL 0x81 by 1 -> 0x02, carry 1.
    issue(8'h81, 3'd2, 3'd1, 1'b1, 8'h02, 1'b1);
    wait_drain(20);

    // LSR 0x81 by 7 (max amount) -> 0x01, carry 0.
    issue(8'h81, 3'd4, 3'd7, 1'b1, 8'h01, 1'b0);
    wait_drain(20);

    // ROR 0x5A by 0 -> done next cycle, unchanged, carry 0.
    issue(8'h5A, 3'd1, 3'd0, 1'b1, 8'h5A, 1'b0);
    wait_drain(20);

    // No-op type 6, amount 4 -> unchanged, carry 0, full latency.
    issue(8'h3C, 3'd6, 3'd4, 1'b1, 8'h3C, 1'b0);
    wait_drain(20);

    // ROL 0x0F by 5 -> 0xE1, carry 1; starts in cycles 2 and 6 ignored.
    issue(8'h0F, 3'd0, 3'd5, 1'b1, 8'hE1, 1'b1);
    @(posedge clk); #1;
    data_in = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    data_in = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    // First start after returning to IDLE: ROR 0x01 by 1 -> 0x80, carry 1.
    issue(8'h01, 3'd1, 3'd1, 1'b1, 8'h80, 1'b1);
    wait_drain(20);

    // LSR 0x96 by 6 aborted by reset in cycle 3: no done, registers cleared.
    issue(8'h96, 3'd4, 3'd6, 1'b0, 8'h00, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_result", result, 8'h00);
    check("abort_carry", carry, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (8) begin
      @(posedge clk); #1;
    end

    // Fresh LSR 0x96 by 6 -> 0x02, carry 0.
    issue(8'h96, 3'd4, 3'd6, 1'b1, 8'h02, 1'b0);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
